// File: rtl/arc4_pkg.sv
// Shared ARC4 key-schedule definitions: KSA state encoding, S-memory
// geometry constants and the key-byte type.
package arc4_pkg;

    localparam int S_SIZE     = 256;
    localparam int MEM_RD_LAT = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        READ_SI,
        WAIT_SI,
        LATCH_SI,
        SWAP_REQ,
        SWAP_WAIT,
        NEXT,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_fsm_key_byte_sel.sv
// Key-byte selector: wrap counter over the secret-key bytes and the byte
// mux feeding the j accumulator. Byte 0 is the most-significant key byte.
module key_byte_sel
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_i,
    input  logic                   adv_i,
    input  logic [8*KEY_BYTES-1:0] secret_key_i,
    output byte_t                  key_byte_o
);

    localparam int            KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

    logic [KW-1:0] k_idx_q;
    logic [KW-1:0] k_idx_d;

    // Next key index: clear, or step with wrap at the last key byte
    always_comb begin
        k_idx_d = k_idx_q;
        if (clr_i) begin
            k_idx_d = '0;
        end else if (adv_i) begin
            k_idx_d = (k_idx_q == K_LAST) ? '0 : k_idx_q + KW'(1);
        end
    end

    // Key index register
    always_ff @(posedge clk) begin
        if (reset) begin
            k_idx_q <= '0;
        end else begin
            k_idx_q <= k_idx_d;
        end
    end

    // Select the addressed key byte, MSB-first ordering
    always_comb begin
        key_byte_o = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_idx_q == KW'(b)) begin
                key_byte_o = secret_key_i[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_fsm.sv
// ARC4 key-scheduling controller. Walks i over the S memory, accumulates j,
// and hands each (i, j) pair to the downstream swap FSM.
// Optional macro KSA_INIT_EN adds an S[n]=n fill phase before the loop.
module ksa_fsm
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             out_mem,
    output logic [7:0]             address,
    output logic                   wren,
    output logic [7:0]             data,
    output logic                   mem_sel,
    output logic [7:0]             counter_i,
    output logic [7:0]             counter_j,
    output logic                   swap_flag,
    input  logic                   swap_done,
    output logic                   busy,
    output logic                   done
);

    localparam byte_t I_LAST = byte_t'(S_SIZE - 1);

    ksa_state_t state_q, state_d;
    byte_t      i_q, i_d;
    byte_t      j_q, j_d;
    byte_t      addr_q, addr_d;
    logic       msel_q, msel_d;
    logic       k_clr, k_adv;
    byte_t      key_byte;
`ifdef KSA_INIT_EN
    byte_t      n_q, n_d;
`endif

    key_byte_sel #(
        .KEY_BYTES(KEY_BYTES)
    ) u_key_sel (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (k_clr),
        .adv_i       (k_adv),
        .secret_key_i(secret_key),
        .key_byte_o  (key_byte)
    );

    // Next-state, datapath updates and strobe outputs
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        addr_d    = addr_q;
        msel_d    = msel_q;
        k_clr     = 1'b0;
        k_adv     = 1'b0;
        swap_flag = 1'b0;
        done      = 1'b0;
`ifdef KSA_INIT_EN
        n_d       = n_q;
`endif
        case (state_q)
            IDLE: begin
                i_d    = '0;
                j_d    = '0;
                addr_d = '0;
                k_clr  = 1'b1;
                if (start) begin
`ifdef KSA_INIT_EN
                    n_d     = '0;
                    state_d = INIT;
`else
                    state_d = READ_SI;
`endif
                end
            end
`ifdef KSA_INIT_EN
            INIT: begin
                if (n_q == I_LAST) begin
                    n_d     = '0;
                    state_d = READ_SI;
                end else begin
                    n_d = n_q + 8'd1;
                end
            end
`endif
            READ_SI: begin
                addr_d  = i_q;
                state_d = WAIT_SI;
            end
            WAIT_SI: begin
                state_d = LATCH_SI;
            end
            LATCH_SI: begin
                j_d     = j_q + out_mem + key_byte;
                state_d = SWAP_REQ;
            end
            SWAP_REQ: begin
                swap_flag = 1'b1;
                msel_d    = 1'b1;
                state_d   = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (swap_done) begin
                    msel_d  = 1'b0;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (i_q == I_LAST) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_adv   = 1'b1;
                    state_d = READ_SI;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any pass in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            msel_q  <= 1'b0;
`ifdef KSA_INIT_EN
            n_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            addr_q  <= addr_d;
            msel_q  <= msel_d;
`ifdef KSA_INIT_EN
            n_q     <= n_d;
`endif
        end
    end

    assign mem_sel   = msel_q;
    assign counter_i = i_q;
    assign counter_j = j_q;
    assign busy      = (state_q != IDLE);
`ifdef KSA_INIT_EN
    assign address   = (state_q == INIT) ? n_q : addr_q;
    assign wren      = (state_q == INIT);
    assign data      = (state_q == INIT) ? n_q : 8'd0;
`else
    assign address   = addr_q;
    assign wren      = 1'b0;
    assign data      = 8'd0;
`endif

endmodule

// File: tb/tb_ksa_fsm.sv
// Self-checking bench for ksa_fsm: behavioural S memory, behavioural swap
// FSM and a software RC4 key-schedule reference.
module tb_ksa_fsm;

    localparam int KB = 3;
`ifdef KSA_INIT_EN
    localparam int INIT_CYC = 256;
`else
    localparam int INIT_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, swap_done;
    logic [23:0] secret_key;
    logic [7:0]  out_mem, address, data, counter_i, counter_j;
    logic        wren, mem_sel, swap_flag, busy, done;

    ksa_fsm #(.KEY_BYTES(KB)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .out_mem(out_mem), .address(address), .wren(wren), .data(data),
        .mem_sel(mem_sel), .counter_i(counter_i), .counter_j(counter_j),
        .swap_flag(swap_flag), .swap_done(swap_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] key;
        int          pat;
        int          ls;
        logic [7:0]  j0, j1, j2;
    } vec_t;

    vec_t       vecs[4];
    int         n_chk = 0, n_fail = 0;
    logic [7:0] mem[256];
    logic [7:0] ref_s[256];
    int         exp_j[256];
    logic [7:0] rd_pend;
    int         n_swaps, done_cyc, first_swap_cyc, seq_err, msel_err, wr_err, wr_cnt, wr_ok;
    logic [7:0] got_i[3], got_j[3];
    bit         aborted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] key_byte(input logic [23:0] key, input int idx);
        return 8'(key >> (8 * (KB - 1 - idx)));
    endfunction

    task automatic load_pattern(input int pat);
        for (int k = 0; k < 256; k++) begin
            if (pat == 2) mem[k] = 8'($urandom);
            else mem[k] = 8'(k);
        end
        if (pat == 1) mem[0] = 8'hF0;
    endtask

    // Software RC4 key schedule on a copy of the starting S contents
    task automatic ref_ksa(input logic [23:0] key);
        int         jj;
        logic [7:0] t;
        jj = 0;
        for (int k = 0; k < 256; k++) ref_s[k] = mem[k];
`ifdef KSA_INIT_EN
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
`endif
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + ref_s[ii] + key_byte(key, ii % KB)) % 256;
            exp_j[ii] = jj;
            t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
        end
    endtask

    task automatic run_pass(input logic [23:0] key, input int ls, input bit hold,
                            input bit spur, input int abort_at);
        int         cyc, cnt, pi, pj, limit;
        logic [7:0] t;
        secret_key = key;
        ref_ksa(key);
        n_swaps = 0; done_cyc = -1; first_swap_cyc = -1; seq_err = 0;
        msel_err = 0; wr_err = 0; wr_cnt = 0; wr_ok = 0; aborted = 0;
        cnt = 0; pi = 0; pj = 0; cyc = 0;
        limit = 256 * (6 + ls) + INIT_CYC + 50;
        @(negedge clk);
        start = 1'b1;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            swap_done = 1'b0;
            if (wren) begin
                if (address == data && data == 8'(wr_cnt) && n_swaps == 0) wr_ok++;
                wr_cnt++;
                mem[address] = data;
            end
            if (INIT_CYC == 0 && (wren !== 1'b0 || data !== 8'd0)) wr_err++;
            out_mem = rd_pend;
            rd_pend = mem[address];
            if (cnt > 0) begin
                if (mem_sel !== 1'b1) msel_err++;
                cnt--;
                if (cnt == 0) begin
                    swap_done = 1'b1;
                    t = mem[pi]; mem[pi] = mem[pj]; mem[pj] = t;
                end
            end else if (spur && $urandom_range(0, 3) == 0) begin
                swap_done = 1'b1;
            end
            if (swap_flag) begin
                if (n_swaps < 3) begin
                    got_i[n_swaps] = counter_i;
                    got_j[n_swaps] = counter_j;
                end
                if (n_swaps == 0) first_swap_cyc = cyc;
                if (n_swaps > 255 || counter_i != 8'(n_swaps) || counter_j != 8'(exp_j[n_swaps]))
                    seq_err++;
                pi = counter_i; pj = counter_j; cnt = ls;
                n_swaps++;
                if (abort_at == int'(counter_i)) begin
                    aborted = 1;
                    break;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic pass_checks(input int ls);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
        check("swap_count", n_swaps, 256);
        check("pass_cycles", done_cyc + 1, 256 * (5 + ls) + 2 + INIT_CYC);
        check("ij_sequence_errors", seq_err, 0);
        check("final_S_mismatches", bad, 0);
        check("mem_sel_during_swap_errors", msel_err, 0);
        check("first_swap_cycle", first_swap_cyc, 4 + INIT_CYC);
`ifdef KSA_INIT_EN
        check("init_writes", wr_cnt, 256);
        check("init_writes_ordered", wr_ok, 256);
`else
        check("wren_data_idle_errors", wr_err, 0);
`endif
    endtask

    initial begin
        vecs[0] = '{key: 24'h010203, pat: 0, ls: 3, j0: 8'h01, j1: 8'h03, j2: 8'h08};
        vecs[1] = '{key: 24'h000000, pat: 0, ls: 9, j0: 8'h00, j1: 8'h01, j2: 8'h03};
        vecs[2] = '{key: 24'hFFFFFF, pat: 1, ls: 2, j0: 8'hEF, j1: 8'hEF, j2: 8'hF0};
        vecs[3] = '{key: 24'h112233, pat: 0, ls: 1, j0: 8'h11, j1: 8'h34, j2: 8'h69};

        reset = 1'b1; start = 1'b0; swap_done = 1'b0; secret_key = '0;
        out_mem = '0; rd_pend = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swap_flag", swap_flag, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_address", address, 0);
        check("rst_counter_i", counter_i, 0);
        check("rst_counter_j", counter_j, 0);
        check("rst_wren", wren, 0);
        check("rst_data", data, 0);
        reset = 1'b0;

        // Table-driven full passes with hand-derived first three swaps
        for (int t = 0; t < 4; t++) begin
            load_pattern(vecs[t].pat);
            run_pass(vecs[t].key, vecs[t].ls, 1'b0, 1'b0, -1);
            pass_checks(vecs[t].ls);
            for (int k = 0; k < 3; k++) check("table_counter_i", got_i[k], k);
            if (INIT_CYC == 0 || vecs[t].pat == 0) begin
                check("table_j0", got_j[0], vecs[t].j0);
                check("table_j1", got_j[1], vecs[t].j1);
                check("table_j2", got_j[2], vecs[t].j2);
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
        end

        // Randomized keys, S contents and swap latency, with spurious swap_done
        for (int r = 0; r < 3; r++) begin
            int ls;
            ls = $urandom_range(1, 5);
            load_pattern(2);
            run_pass(24'($urandom), ls, 1'b0, 1'b1, -1);
            pass_checks(ls);
            @(negedge clk);
        end

        // start held high: no restart until done, then restart next cycle
        load_pattern(0);
        run_pass(24'($urandom), 2, 1'b1, 1'b0, -1);
        pass_checks(2);
        @(negedge clk);
        check("hold_idle_after_done", busy, 0);
        @(negedge clk);
        check("hold_restart", busy, 1);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("hold_reset_busy", busy, 0);

        // Reset in SWAP_WAIT at i=17, coinciding with swap_done
        load_pattern(0);
        run_pass(24'h010203, 4, 1'b0, 1'b0, 17);
        check("abort_reached_i17", aborted, 1);
        @(negedge clk);
        check("abort_in_swap_wait", mem_sel, 1);
        reset = 1'b1; swap_done = 1'b1;
        @(negedge clk);
        reset = 1'b0; swap_done = 1'b0;
        check("abort_outputs_zero",
              {busy, done, swap_flag, mem_sel, wren, address, counter_i, counter_j, data}, 0);
        begin
            int stray;
            stray = 0;
            repeat (10) begin
                @(negedge clk);
                if (swap_flag || busy) stray++;
            end
            check("abort_no_activity", stray, 0);
        end
        load_pattern(0);
        run_pass(24'h010203, 2, 1'b0, 1'b0, -1);
        pass_checks(2);
        check("restart_i0", got_i[0], 0);
        check("restart_j0", got_j[0], 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- Key-scheduling controller for the ARC4 datapath; sits directly upstream of the swap FSM.
- Walks i = 0..255 over the 256-byte S memory.
- Per iteration: reads s[i], computes j = j + s[i] + key[i mod KEY_BYTES], then hands i/j to the swap FSM through the swap_flag/swap_done handshake.
- Owns the S-memory read port except while a swap is in progress.

Parameters:
- KEY_BYTES, 3: number of secret-key bytes; key index wraps at KEY_BYTES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE only; begins a KSA pass
- secret_key  in  8*KEY_BYTES  key; byte 0 = most-significant byte
- out_mem  in  8  S-memory read data
- address  out  8  S-memory address driven by this block
- wren  out  1  S-memory write enable (init phase only)
- data  out  8  S-memory write data (init phase only)
- mem_sel  out  1  1 = swap FSM owns the memory port; 0 = this block owns it
- counter_i  out  8  current i, to swap FSM
- counter_j  out  8  current j, to swap FSM
- swap_flag  out  1  one-cycle swap request
- swap_done  in  1  one-cycle completion from swap FSM
- busy  out  1  high from leaving IDLE until DONE exits
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is synchronous and active-high.
  - On reset: state=IDLE; i=j=k_idx=0; all outputs 0.
  - Reset mid-pass aborts immediately; no further swap_flag.
- Memory timing: address registered; out_mem sampled two cycles after address is driven.
- States:
  - IDLE: hold i=j=k_idx=0. If start=1, go to READ_SI, or to INIT when KSA_INIT_EN is defined.
  - READ_SI: address<=i; go to WAIT_SI.
  - WAIT_SI: go to LATCH_SI.
  - LATCH_SI: j <= j + out_mem + key_byte[k_idx], 8-bit, wrap mod 256 with carries discarded; go to SWAP_REQ.
  - SWAP_REQ:
    - swap_flag=1 for exactly this cycle.
    - counter_i=i and counter_j=new j, stable from here until swap_done.
    - mem_sel<=1. Go to SWAP_WAIT.
  - SWAP_WAIT: hold all registers; on swap_done=1: mem_sel<=0, go to NEXT. No timeout.
  - NEXT:
    - If i==255, go to DONE.
    - Else i<=i+1 and k_idx<=(k_idx==KEY_BYTES-1)?0:k_idx+1; go to READ_SI.
  - DONE: done=1 for one cycle; busy drops; go to IDLE.
- Key indexing uses a wrap counter, not division.
- Boundaries:
  - i wraps only via IDLE; j wraps silently.
  - The i==255 iteration still performs its swap.
- Ignored or fixed events:
  - start while busy: ignored.
  - swap_done outside SWAP_WAIT: ignored.
  - swap_done on the same cycle as reset: reset wins.
  - A new start is accepted the cycle after DONE returns to IDLE.
- Cycle counts:
  - Per iteration: 5 cycles plus swap FSM latency.
  - Total pass: 256*(5+Ls)+2.
- wren and data stay 0 outside INIT.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined:
  - Adds an INIT state before the loop: writes s[n]=n for n=0..255, one write per cycle (wren=1, address=n, data=n, mem_sel=0).
  - After n=255, clears n and enters READ_SI. Adds 256 cycles.
- Undefined:
  - No INIT state; S is assumed pre-initialised by an external fill FSM.
  - wren and data tied to 0.

Decomposition:
- Shared package arc4_pkg:
  - ksa_state_t enum.
  - Constants S_SIZE=256 and MEM_RD_LAT=2.
  - Key-byte type byte_t.
- Sub-module key_byte_sel:
  - Holds the k_idx wrap counter plus the byte mux from secret_key.
  - Parameterised by KEY_BYTES.
- FSM and j arithmetic stay in ksa_fsm.

Test Plan:
- Key 24'h010203, identity S, behavioural swap model:
  - Iteration 0: j=1, swap (0,1).
  - Iteration 1: s[1]=0, j=3.
  - Iteration 2: s[2]=2, j=8.
  - Check counter_i/counter_j at each swap_flag.
- Full pass, key 24'h000000, model swap latency Ls=9:
  - Exactly 256 swap_flag pulses, one done pulse.
  - Total cycles 256*14+2.
  - Final S matches software RC4 KSA.
- Reset asserted in SWAP_WAIT at i=17:
  - Next cycle all outputs 0, state IDLE, no swap_flag.
  - A subsequent start runs from i=0.
- Handshake robustness:
  - start held high through the pass: no restart until after done.
  - Spurious swap_done in READ_SI: ignored, j unchanged.
- j wrap, key 24'hFFFFFF with S forced so s[i]=8'hF0 at i=0:
  - j = 0+F0+FF = 8'hEF.
- With KSA_INIT_EN:
  - 256 writes s[n]=n observed before the first swap_flag.
  - First READ_SI occurs at cycle 257 after start.
